food_placer: RTL
================

# food_placer

Consumer side of the game's coordinate generator. On each placement request it samples the free-running random (x, y) pair, checks it against the playfield bounds and the snake-occupancy lookup, and retries until it finds a free cell or exhausts its retry budget. It then publishes the food position to the game controller and the renderer.

## Interface
Parameters:
- X_MAX, 38, largest legal column; legal x is 1..X_MAX
- Y_MAX, 28, largest legal row; legal y is 1..Y_MAX
- MAX_TRIES, 16, candidate samples per request before giving up (range 1..255)

Ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- rand_x  in  6  random column from generator; changes every clk
- rand_y  in  5  random row from generator; changes every clk
- place_req  in  1  one-cycle request for a new food position
- food_clear  in  1  drop current food and abort any search (game over/restart)
- occ_req  out  1  occupancy query strobe
- occ_x  out  6  queried column
- occ_y  out  5  queried row
- occ_hit  in  1  1 = queried cell holds snake body; valid exactly 1 cycle after occ_req
- food_x  out  6  current food column
- food_y  out  5  current food row
- food_valid  out  1  food_x/food_y hold a placed food
- busy  out  1  search in progress
- place_done  out  1  one-cycle pulse: new food published
- place_fail  out  1  one-cycle pulse: MAX_TRIES exhausted; previous food unchanged

## Operation
- States: IDLE, SAMPLE, LOOKUP, DECIDE.
- IDLE: busy=0. When place_req=1 and food_clear=0, clear the try counter and go to SAMPLE.
- SAMPLE: latch rand_x/rand_y into the candidate and increment the try counter.
  - In range (x 1..X_MAX and y 1..Y_MAX): go to LOOKUP.
  - Out of range, including 0: reject with no query. Stay in SAMPLE if tries < MAX_TRIES, else go to fail.
- LOOKUP: occ_req=1, occ_x/occ_y=candidate (registered outputs). Go to DECIDE.
- DECIDE: sample occ_hit.
  - occ_hit=0: load food_x/food_y with the candidate, set food_valid=1, pulse place_done, go to IDLE.
  - occ_hit=1 and tries < MAX_TRIES: go to SAMPLE.
  - Otherwise: fail.
- Fail: pulse place_fail, go to IDLE. food_x/food_y/food_valid are unchanged.
- food_clear=1 in any state: food_valid=0, go to IDLE. No place_done or place_fail pulse. food_clear has priority over place_req and over a same-cycle DECIDE success.
- place_req while busy=1 is ignored; it is not queued.
- The try counter is 8 bits and saturates at MAX_TRIES; it never wraps.
- occ_req is 0 in every state except LOOKUP.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Timing
- Reset values: food_x=0, food_y=0, food_valid=0, busy=0, place_done=0, place_fail=0, occ_req=0, occ_x=0, occ_y=0, state=IDLE, try counter=0.
- Reset assertion is asynchronous and aborts a search mid-flight. Release is synchronized to clk.
- Request at cycle N, first candidate free:
  - SAMPLE at N+1.
  - occ_req high during N+2.
  - occ_hit sampled at N+3.
  - food and place_done visible in N+4.
  - Latency is 4 cycles.
- Each occupied-cell retry adds 3 cycles. Each out-of-range retry adds 1 cycle.
- Worst case with all samples hitting occupied cells: 1 + 3·MAX_TRIES cycles to place_fail (49 cycles at the defaults).
- busy is high from N+1 through the cycle before IDLE is re-entered.
- place_done and place_fail are exactly one cycle wide and never asserted together.

## Structure
- Shared package snake_pkg holds:
  - X_MAX/Y_MAX defaults and coordinate widths (6/5)
  - the placer state enum
  - the localparam for the try-counter width
- Single module, no sub-modules. The range check is an inline function in the package so that the generator's testbench can reuse it.

## Test plan
- Reset mid-search: drop reset low during LOOKUP -> all outputs return to reset values immediately; after release, IDLE and busy=0.
- Free first sample: rand=(5,7), occ_hit=0, place_req at N -> occ_req with (5,7) in N+2; food=(5,7), food_valid=1, place_done in N+4.
- Occupied then free: rand=(5,7) then (12,3), occ_hit=1 then 0 -> two queries; food=(12,3) with place_done at N+7.
- Out of range: rand=(0,9), then (40,9), then (38,28) -> no query for the first two; food=(38,28) at N+6.
- Exhaustion: MAX_TRIES=4, occ_hit always 1, prior food (3,3) -> place_fail at N+13; food stays (3,3), food_valid=1.
- Clear priority: food_clear asserted in the DECIDE cycle with occ_hit=0 -> food_valid=0, no place_done; place_req during busy -> ignored.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared definitions for the snake game datapath.
// Holds playfield defaults, coordinate widths, the food-placer state
// encoding and the playfield range check reused by other blocks.
package snake_pkg;

    localparam int unsigned X_W       = 6;
    localparam int unsigned Y_W       = 5;
    localparam int unsigned X_MAX_DEF = 38;
    localparam int unsigned Y_MAX_DEF = 28;
    localparam int unsigned TRY_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_LOOKUP,
        ST_DECIDE
    } placer_state_e;

    // Legal cells are 1..x_max by 1..y_max; row/column 0 is the wall.
    function automatic logic coord_in_range(
        input logic [X_W-1:0] x,
        input logic [Y_W-1:0] y,
        input int unsigned    x_max,
        input int unsigned    y_max
    );
        return (x != '0) && (32'(x) <= x_max) &&
               (y != '0) && (32'(y) <= y_max);
    endfunction

endpackage

// File: rtl/food_placer.sv
// Food placer: on request, samples random (x, y) candidates, rejects
// off-field ones, queries snake occupancy for the rest and publishes the
// first free cell, or gives up after MAX_TRIES candidates.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   rand_x, rand_y    free-running random candidate
//   place_req         one-cycle placement request
//   food_clear        drop food and abort any search
//   occ_req/x/y       occupancy query (registered)
//   occ_hit           occupancy answer, one cycle after occ_req
//   food_x/y/valid    current food position
//   busy              search in progress
//   place_done/fail   one-cycle result pulses
module food_placer
    import snake_pkg::*;
#(
    parameter int unsigned X_MAX     = X_MAX_DEF,
    parameter int unsigned Y_MAX     = Y_MAX_DEF,
    parameter int unsigned MAX_TRIES = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [X_W-1:0] rand_x,
    input  logic [Y_W-1:0] rand_y,
    input  logic           place_req,
    input  logic           food_clear,
    output logic           occ_req,
    output logic [X_W-1:0] occ_x,
    output logic [Y_W-1:0] occ_y,
    input  logic           occ_hit,
    output logic [X_W-1:0] food_x,
    output logic [Y_W-1:0] food_y,
    output logic           food_valid,
    output logic           busy,
    output logic           place_done,
    output logic           place_fail
);

    localparam logic [TRY_W-1:0] TRY_LIMIT = TRY_W'(MAX_TRIES);

    placer_state_e    r_state,      w_state_nxt;
    logic [TRY_W-1:0] r_tries,      w_tries_nxt;
    logic [X_W-1:0]   r_cand_x,     w_cand_x_nxt;
    logic [Y_W-1:0]   r_cand_y,     w_cand_y_nxt;
    logic [X_W-1:0]   r_food_x,     w_food_x_nxt;
    logic [Y_W-1:0]   r_food_y,     w_food_y_nxt;
    logic             r_food_valid, w_food_valid_nxt;
    logic             r_busy,       w_busy_nxt;
    logic             r_done,       w_done_nxt;
    logic             r_fail,       w_fail_nxt;
    logic             r_occ_req,    w_occ_req_nxt;

    logic [TRY_W-1:0] w_tries_inc;
    logic             w_in_range;

    // Try counter saturates at the budget instead of wrapping.
    assign w_tries_inc = (r_tries >= TRY_LIMIT) ? TRY_LIMIT : r_tries + TRY_W'(1);
    assign w_in_range  = coord_in_range(rand_x, rand_y, X_MAX, Y_MAX);

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt      = r_state;
        w_tries_nxt      = r_tries;
        w_cand_x_nxt     = r_cand_x;
        w_cand_y_nxt     = r_cand_y;
        w_food_x_nxt     = r_food_x;
        w_food_y_nxt     = r_food_y;
        w_food_valid_nxt = r_food_valid;
        w_done_nxt       = 1'b0;
        w_fail_nxt       = 1'b0;

        if (food_clear) begin
            // Clear wins over a new request and over a same-cycle success.
            w_state_nxt      = ST_IDLE;
            w_food_valid_nxt = 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (place_req) begin
                        w_tries_nxt = '0;
                        w_state_nxt = ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    w_cand_x_nxt = rand_x;
                    w_cand_y_nxt = rand_y;
                    w_tries_nxt  = w_tries_inc;
                    if (w_in_range) begin
                        w_state_nxt = ST_LOOKUP;
                    end else if (w_tries_inc < TRY_LIMIT) begin
                        w_state_nxt = ST_SAMPLE;
                    end else begin
                        w_fail_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_LOOKUP: begin
                    w_state_nxt = ST_DECIDE;
                end
                ST_DECIDE: begin
                    if (!occ_hit) begin
                        w_food_x_nxt     = r_cand_x;
                        w_food_y_nxt     = r_cand_y;
                        w_food_valid_nxt = 1'b1;
                        w_done_nxt       = 1'b1;
                        w_state_nxt      = ST_IDLE;
                    end else if (r_tries < TRY_LIMIT) begin
                        w_state_nxt = ST_SAMPLE;
                    end else begin
                        w_fail_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end

        // Status outputs follow the state being entered so they are registered.
        w_busy_nxt    = (w_state_nxt != ST_IDLE);
        w_occ_req_nxt = (w_state_nxt == ST_LOOKUP);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_tries      <= '0;
            r_cand_x     <= '0;
            r_cand_y     <= '0;
            r_food_x     <= '0;
            r_food_y     <= '0;
            r_food_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_fail       <= 1'b0;
            r_occ_req    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_tries      <= w_tries_nxt;
            r_cand_x     <= w_cand_x_nxt;
            r_cand_y     <= w_cand_y_nxt;
            r_food_x     <= w_food_x_nxt;
            r_food_y     <= w_food_y_nxt;
            r_food_valid <= w_food_valid_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_fail       <= w_fail_nxt;
            r_occ_req    <= w_occ_req_nxt;
        end
    end

    // The candidate register doubles as the query address.
    assign occ_req    = r_occ_req;
    assign occ_x      = r_cand_x;
    assign occ_y      = r_cand_y;
    assign food_x     = r_food_x;
    assign food_y     = r_food_y;
    assign food_valid = r_food_valid;
    assign busy       = r_busy;
    assign place_done = r_done;
    assign place_fail = r_fail;

endmodule
